// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions: PC-source encodings, the NOP word and the
// default 32-bit layout of a fetched instruction pair.
package pipeline_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_JR     = 2'b11
  } pcsrc_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr0;
    logic [31:0] instr1;
    logic [31:0] pair_pc;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
interface fetch_queue_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                     imem_req_valid;
  logic                     imem_req_ready;
  logic [PC_WIDTH-1:0]      imem_req_addr;
  logic                     imem_rsp_valid;
  logic [2*INSTR_WIDTH-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Show-ahead FIFO of fetched pairs; the head is readable combinationally,
// flush empties it and wins over a simultaneous push.
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_pair_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  T     mem [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign head    = mem[rd_ptr_q[AW-1:0]];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue fetch stage: PC and request credits, stale-response dropping after
// redirects, misaligned-target slot-0 squash, and the decode-facing head pair.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int                 PC_WIDTH        = 32,
  parameter int                 INSTR_WIDTH     = 32,
  parameter int                 DEPTH           = 4,
  parameter int                 MAX_OUTSTANDING = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_queue_if.master          imem,
  input  logic                   stall_d,
  input  logic [1:0]             pcsrc_d_0,
  input  logic [1:0]             pcsrc_d_1,
  input  logic [PC_WIDTH-1:0]    pc_branch_d_0,
  input  logic [PC_WIDTH-1:0]    pc_branch_d_1,
  input  logic [PC_WIDTH-1:0]    pc_jump_d_0,
  input  logic [PC_WIDTH-1:0]    pc_jump_d_1,
  input  logic [PC_WIDTH-1:0]    pc_jr_d,
  output logic                   valid_d,
  output logic [INSTR_WIDTH-1:0] instr_d_0,
  output logic [INSTR_WIDTH-1:0] instr_d_1,
  output logic [PC_WIDTH-1:0]    pc_plus_8_d_0,
  output logic [PC_WIDTH-1:0]    pc_plus_8_d_1
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr0;
    logic [INSTR_WIDTH-1:0] instr1;
    logic [PC_WIDTH-1:0]    pair_pc;
  } pair_t;

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]       outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic                half_skip_q, half_skip_d, started_q;
  logic                fire, rsp_accept, push, pop, redirect, fifo_empty, fifo_full;
  logic [CW-1:0]       occupancy;
  logic [PC_WIDTH-1:0] target, target_aligned;
  pair_t               push_pair, head_pair;

  // started_q keeps the request line low until the first edge after reset.
  assign imem.imem_req_valid = started_q
                             && ((int'(occupancy) + int'(outstanding_q)) < DEPTH)
                             && (int'(outstanding_q) < MAX_OUTSTANDING);
  assign imem.imem_req_addr  = fetch_pc_q;

  assign fire       = imem.imem_req_valid & imem.imem_req_ready;
  assign rsp_accept = imem.imem_rsp_valid && (outstanding_q != '0);
  assign pop        = valid_d & ~stall_d;
  assign redirect   = pop && ((pcsrc_d_0 != PCSRC_SEQ) || (pcsrc_d_1 != PCSRC_SEQ));
  assign push       = rsp_accept && (drop_cnt_q == '0) && !redirect && !fifo_full;

  always_comb begin
    target = fetch_pc_q;
    if (pcsrc_d_0 != PCSRC_SEQ) begin
      case (pcsrc_e'(pcsrc_d_0))
        PCSRC_BRANCH: target = pc_branch_d_0;
        PCSRC_JUMP:   target = pc_jump_d_0;
        PCSRC_JR:     target = pc_jr_d;
        default:      target = fetch_pc_q;
      endcase
    end else begin
      case (pcsrc_e'(pcsrc_d_1))
        PCSRC_BRANCH: target = pc_branch_d_1;
        PCSRC_JUMP:   target = pc_jump_d_1;
        PCSRC_JR:     target = pc_jr_d;
        default:      target = fetch_pc_q;
      endcase
    end
  end

  assign target_aligned = target & ~PC_WIDTH'(7);

  always_comb begin
    push_pair.instr0  = half_skip_q ? INSTR_WIDTH'(NOP_INSTR) : imem.imem_rsp_data[INSTR_WIDTH-1:0];
    push_pair.instr1  = imem.imem_rsp_data[2*INSTR_WIDTH-1:INSTR_WIDTH];
    push_pair.pair_pc = rsp_pc_q;
  end

  // Responses that survive dropping arrive in address order from the last
  // redirect target, so their pair address is tracked with one counter.
  always_comb begin
    outstanding_d = outstanding_q + OW'(fire) - OW'(rsp_accept);
    drop_cnt_d    = drop_cnt_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    half_skip_d   = half_skip_q;
    if (redirect) begin
      drop_cnt_d  = outstanding_d;
      fetch_pc_d  = target_aligned;
      rsp_pc_d    = target_aligned;
      half_skip_d = target[2];
    end else begin
      if (rsp_accept && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OW'(1);
      if (fire) fetch_pc_d = fetch_pc_q + PC_WIDTH'(8);
      if (push) begin
        rsp_pc_d    = rsp_pc_q + PC_WIDTH'(8);
        half_skip_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      half_skip_q   <= 1'b0;
      started_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      half_skip_q   <= half_skip_d;
      started_q     <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (pair_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_pair),
    .pop       (pop),
    .flush     (redirect),
    .head      (head_pair),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  assign valid_d       = ~fifo_empty;
  assign instr_d_0     = valid_d ? head_pair.instr0 : '0;
  assign instr_d_1     = valid_d ? head_pair.instr1 : '0;
  assign pc_plus_8_d_0 = valid_d ? head_pair.pair_pc + PC_WIDTH'(8)  : '0;
  assign pc_plus_8_d_1 = valid_d ? head_pair.pair_pc + PC_WIDTH'(12) : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed stream/backpressure/reset sequences, a table of
// redirect vectors, and a randomized run checked against an address-stream model.
module tb_fetch_queue;
  import pipeline_pkg::*;

  localparam int          PCW      = 32;
  localparam int          IW       = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_d;
  logic [1:0]  pcsrc_d_0, pcsrc_d_1;
  logic [31:0] pc_branch_d_0, pc_branch_d_1, pc_jump_d_0, pc_jump_d_1, pc_jr_d;
  logic        valid_d;
  logic [31:0] instr_d_0, instr_d_1, pc_plus_8_d_0, pc_plus_8_d_1;

  always #5 clk = ~clk;

  fetch_queue_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW)) imem ();

  fetch_queue #(
    .PC_WIDTH(PCW), .INSTR_WIDTH(IW), .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset), .imem(imem), .stall_d(stall_d),
    .pcsrc_d_0(pcsrc_d_0), .pcsrc_d_1(pcsrc_d_1),
    .pc_branch_d_0(pc_branch_d_0), .pc_branch_d_1(pc_branch_d_1),
    .pc_jump_d_0(pc_jump_d_0), .pc_jump_d_1(pc_jump_d_1), .pc_jr_d(pc_jr_d),
    .valid_d(valid_d), .instr_d_0(instr_d_0), .instr_d_1(instr_d_1),
    .pc_plus_8_d_0(pc_plus_8_d_0), .pc_plus_8_d_1(pc_plus_8_d_1)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [1:0]  pc0, pc1;
    logic [31:0] br0, br1, j0, j1, jr;
    logic [31:0] exp_fetch;
    bit          exp_skip;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Stimulus knobs
  int          ready_p, stall_p, redir_p, lat_max;
  bit          force_redir;
  logic [1:0]  f_pc0, f_pc1;
  logic [31:0] f_br0, f_br1, f_j0, f_j1, f_jr;

  // Reference model: the address stream decode must see, and the request stream
  logic [31:0] exp_addr, exp_req, chk_tgt;
  bit          exp_skip, chk_redir;
  int          cyc, last_due, first_valid_cyc, pop_cnt, fire_cnt;
  logic [63:0] first_pc8;
  int          fire_cyc[$];
  logic [31:0] fire_addr[$];
  pend_t       pending[$];
  vec_t        vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] rnd_tgt();
    return 32'($urandom_range(2047)) << 2;
  endfunction

  task automatic model_reset();
    exp_addr = RESET_PC;
    exp_req  = RESET_PC;
    exp_skip = 1'b0;
    chk_redir = 1'b0;
    pending.delete();
    fire_cyc.delete();
    fire_addr.delete();
    last_due = 0;
    first_valid_cyc = -1;
    pop_cnt = 0;
    fire_cnt = 0;
  endtask

  // One clock cycle: called at a falling edge, returns at the next falling edge.
  task automatic run_cycle();
    logic [1:0]   s0, s1;
    logic [31:0]  tgt, addr;
    logic [127:0] exp_head;
    bit           stl, rdy;
    int           due;
    if (chk_redir) begin
      check("redir_valid_low", valid_d, 0);
      check("redir_req_addr", imem.imem_req_addr, chk_tgt);
      chk_redir = 1'b0;
    end
    if (!valid_d) check("idle_outputs_zero", {instr_d_0, instr_d_1, pc_plus_8_d_0, pc_plus_8_d_1}, 0);
    if (imem.imem_req_valid) check("credit_limit", pending.size() < MAXO, 1);
    if (valid_d && first_valid_cyc < 0) begin
      first_valid_cyc = cyc;
      first_pc8 = {pc_plus_8_d_0, pc_plus_8_d_1};
    end

    rdy = int'($urandom_range(99)) < ready_p;
    stl = int'($urandom_range(99)) < stall_p;
    if (force_redir) begin
      stl = 1'b0;
      s0 = f_pc0; s1 = f_pc1;
      pc_branch_d_0 = f_br0; pc_branch_d_1 = f_br1;
      pc_jump_d_0 = f_j0; pc_jump_d_1 = f_j1; pc_jr_d = f_jr;
    end else begin
      s0 = (int'($urandom_range(99)) < redir_p) ? 2'($urandom_range(3)) : 2'b00;
      s1 = (int'($urandom_range(99)) < redir_p) ? 2'($urandom_range(3)) : 2'b00;
      pc_branch_d_0 = rnd_tgt(); pc_branch_d_1 = rnd_tgt();
      pc_jump_d_0 = rnd_tgt(); pc_jump_d_1 = rnd_tgt(); pc_jr_d = rnd_tgt();
    end
    stall_d = stl;
    pcsrc_d_0 = s0;
    pcsrc_d_1 = s1;
    imem.imem_req_ready = rdy;

    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = {mem_word(pending[0].addr + 32'd4), mem_word(pending[0].addr)};
      pending.delete(0);
    end else begin
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = {$urandom, $urandom};
    end

    if (imem.imem_req_valid && rdy) begin
      addr = imem.imem_req_addr;
      check("req_addr", addr, exp_req);
      due = cyc + int'($urandom_range(lat_max, 1));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pending.push_back('{addr: addr, due: due});
      fire_cyc.push_back(cyc);
      fire_addr.push_back(addr);
      exp_req = exp_req + 32'd8;
      fire_cnt++;
    end

    if (valid_d && !stl) begin
      exp_head = {exp_skip ? 32'h0 : mem_word(exp_addr), mem_word(exp_addr + 32'd4),
                  exp_addr + 32'd8, exp_addr + 32'd12};
      check("pop_head", {instr_d_0, instr_d_1, pc_plus_8_d_0, pc_plus_8_d_1}, exp_head);
      $display("[TB] cyc %0d pop pc+8=%h i0=%h i1=%h pcsrc=%b/%b", cyc, pc_plus_8_d_0,
               instr_d_0, instr_d_1, s0, s1);
      pop_cnt++;
      tgt = 32'h0;
      if (s0 != 2'b00)
        tgt = (s0 == 2'b01) ? pc_branch_d_0 : (s0 == 2'b10) ? pc_jump_d_0 : pc_jr_d;
      else if (s1 != 2'b00)
        tgt = (s1 == 2'b01) ? pc_branch_d_1 : (s1 == 2'b10) ? pc_jump_d_1 : pc_jr_d;
      if (s0 != 2'b00 || s1 != 2'b00) begin
        exp_addr  = {tgt[31:3], 3'b000};
        exp_skip  = tgt[2];
        exp_req   = exp_addr;
        chk_redir = 1'b1;
        chk_tgt   = exp_addr;
      end else begin
        exp_addr = exp_addr + 32'd8;
        exp_skip = 1'b0;
      end
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!valid_d && n < 50) begin
      run_cycle();
      n++;
    end
    if (!valid_d) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    vecs[0] = '{2'b01, 2'b00, 32'h100, 32'h1114, 32'h1220, 32'h1324, 32'h1428, 32'h100, 1'b0};
    vecs[1] = '{2'b00, 2'b11, 32'h1100, 32'h1114, 32'h1220, 32'h1324, 32'h204, 32'h200, 1'b1};
    vecs[2] = '{2'b10, 2'b01, 32'h1100, 32'h480, 32'h340, 32'h1324, 32'h1428, 32'h340, 1'b0};
    vecs[3] = '{2'b00, 2'b10, 32'h1100, 32'h1114, 32'h1220, 32'h50C, 32'h1428, 32'h508, 1'b1};
    vecs[4] = '{2'b11, 2'b10, 32'h1100, 32'h1114, 32'h1220, 32'h700, 32'h60, 32'h60, 1'b0};
    vecs[5] = '{2'b00, 2'b01, 32'h1100, 32'h7FC, 32'h1220, 32'h1324, 32'h1428, 32'h7F8, 1'b1};

    stall_d = 1'b0; pcsrc_d_0 = 2'b00; pcsrc_d_1 = 2'b00;
    pc_branch_d_0 = '0; pc_branch_d_1 = '0; pc_jump_d_0 = '0; pc_jump_d_1 = '0; pc_jr_d = '0;
    imem.imem_req_ready = 1'b0; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = '0;
    ready_p = 100; stall_p = 0; redir_p = 0; lat_max = 1; force_redir = 1'b0;
    f_pc0 = '0; f_pc1 = '0; f_br0 = '0; f_br1 = '0; f_j0 = '0; f_j1 = '0; f_jr = '0;
    first_pc8 = '0;
    model_reset();

    // Reset values, then the first requests and first delivered pair
    repeat (3) @(negedge clk);
    check("rst_req_valid", imem.imem_req_valid, 0);
    check("rst_req_addr", imem.imem_req_addr, RESET_PC);
    check("rst_valid_d", valid_d, 0);
    check("rst_outputs", {instr_d_0, instr_d_1, pc_plus_8_d_0, pc_plus_8_d_1}, 0);
    reset = 1'b1;
    cyc = 0;
    check("req_valid_at_release", imem.imem_req_valid, 0);
    repeat (12) run_cycle();
    if (fire_cyc.size() < 3) begin
      check("stream_fire_count", fire_cyc.size(), 3);
    end else begin
      check("first_fire_cycle", fire_cyc[0], 1);
      check("fire_addr0", fire_addr[0], 32'h0);
      check("fire_addr1", fire_addr[1], 32'h8);
      check("fire_addr2", fire_addr[2], 32'h10);
      check("fire_back_to_back", fire_cyc[2] - fire_cyc[0], 2);
      check("fire_to_valid", first_valid_cyc - fire_cyc[0], 2);
    end
    check("first_pc_plus_8", first_pc8, {32'h8, 32'hC});

    // Table of redirect vectors: slot priority, target kinds, misaligned targets
    for (int i = 0; i < 6; i++) begin
      wait_valid($sformatf("vec%0d_pre", i));
      f_pc0 = vecs[i].pc0; f_pc1 = vecs[i].pc1;
      f_br0 = vecs[i].br0; f_br1 = vecs[i].br1;
      f_j0 = vecs[i].j0; f_j1 = vecs[i].j1; f_jr = vecs[i].jr;
      force_redir = 1'b1;
      run_cycle();
      force_redir = 1'b0;
      check($sformatf("vec%0d_valid_low", i), valid_d, 0);
      check($sformatf("vec%0d_req_addr", i), imem.imem_req_addr, vecs[i].exp_fetch);
      wait_valid($sformatf("vec%0d_post", i));
      check($sformatf("vec%0d_first_pair", i), {instr_d_0, instr_d_1, pc_plus_8_d_0},
            {vecs[i].exp_skip ? 32'h0 : mem_word(vecs[i].exp_fetch),
             mem_word(vecs[i].exp_fetch + 32'd4), vecs[i].exp_fetch + 32'd8});
    end

    // Reset in the middle of a stalled stream
    stall_p = 100;
    repeat (3) run_cycle();
    check("mid_reset_queue_nonempty", valid_d, 1);
    #2;
    reset = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    #1;
    check("mid_rst_req_valid", imem.imem_req_valid, 0);
    check("mid_rst_req_addr", imem.imem_req_addr, RESET_PC);
    check("mid_rst_valid_d", valid_d, 0);
    check("mid_rst_outputs", {instr_d_0, instr_d_1, pc_plus_8_d_0, pc_plus_8_d_1}, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    check("mid_rst_release_req_valid", imem.imem_req_valid, 0);

    // Backpressure from a fresh start: credits cap requests at DEPTH pairs
    repeat (15) run_cycle();
    check("bp_fire_count", fire_cnt, DEPTH);
    check("bp_req_valid_low", imem.imem_req_valid, 0);
    check("bp_head_valid", valid_d, 1);
    stall_p = 0;
    repeat (12) run_cycle();
    check("bp_drain_pops", pop_cnt >= DEPTH, 1);

    // Randomized traffic: ready, latency, stalls and redirects
    ready_p = 70; stall_p = 30; redir_p = 12; lat_max = 3;
    repeat (400) run_cycle();
    check("random_made_progress", pop_cnt > 20, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
